// File: rtl/exe_stage.sv
// Execute stage: effective address, ALE detection and
// SRAM-like data request handshake toward the memory stage.
module exe_stage #(
  parameter logic [5:0] ECODE_ALE = 6'h09,
  parameter int         DEST_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              final_ex,
  input  logic              back_ertn_flush,
  input  logic              ds_to_es_valid,
  output logic              es_allowin,
  input  logic [7:0]        ds_mem_op,
  input  logic [31:0]       ds_base,
  input  logic [31:0]       ds_offset,
  input  logic [31:0]       ds_st_data,
  input  logic [31:0]       ds_pc,
  input  logic [DEST_W-1:0] ds_dest,
  input  logic              ds_gr_we,
  input  logic              ds_ex,
  input  logic [5:0]        ds_ecode,
  input  logic              ms_allowin,
  input  logic              ms_to_es_ex,
  input  logic              ws_to_es_ex,
  output logic              es_to_ms_valid,
  output logic [31:0]       es_addr,
  output logic [7:0]        es_mem_op,
  output logic [31:0]       es_pc,
  output logic [DEST_W-1:0] es_dest,
  output logic              es_gr_we,
  output logic              es_ex,
  output logic [5:0]        es_ecode,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  output logic              es_orphan_req
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACC
  } state_t;

  state_t      state;
  logic        es_valid;
  logic        orphan;
  logic [31:0] es_base;
  logic [31:0] es_offset;
  logic [31:0] es_st_data;
  logic        es_ds_ex;
  logic [5:0]  es_ds_ecode;

  logic squash;
  logic older;
  logic is_mem;
  logic op_w;
  logic op_h;
  logic ale;
  logic issue_ok;
  logic ready_go;
  logic handoff;
  logic acc_cyc;

  assign squash  = final_ex | back_ertn_flush;
  assign older   = ms_to_es_ex | ws_to_es_ex;
  assign is_mem  = |es_mem_op;
  assign op_w    = es_mem_op[0] | es_mem_op[5];
  assign op_h    = es_mem_op[3] | es_mem_op[4]
                 | es_mem_op[6];
  assign es_addr = es_base + es_offset;

  assign ale = (op_w & |es_addr[1:0])
             | (op_h & es_addr[0]);

  assign es_ex    = es_valid & (es_ds_ex | ale);
  assign es_ecode = !es_ex    ? 6'h00 :
                    es_ds_ex  ? es_ds_ecode :
                                ECODE_ALE;

  assign issue_ok = es_valid & is_mem & !es_ex
                  & !older & !squash;

  assign acc_cyc  = (state == REQ) & data_sram_addr_ok;

  assign ready_go = !is_mem | es_ex
                  | (state == ACC) | acc_cyc
                  | ((state == IDLE) & older);

  assign es_allowin = !orphan
                    & (!es_valid | (ready_go & ms_allowin));

  assign es_to_ms_valid = es_valid & ready_go & !squash;
  assign handoff        = es_to_ms_valid & ms_allowin;

  assign es_orphan_req = (acc_cyc & (orphan | squash))
                       | ((state == ACC) & squash);

  assign data_sram_req  = (state == REQ);
  assign data_sram_wr   = |es_mem_op[7:5];
  assign data_sram_addr = es_addr;
  assign data_sram_size = op_w ? 2'd2 :
                          op_h ? 2'd1 : 2'd0;

  // Store lane strobes and replicated write data
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = es_st_data;
    unique case (1'b1)
      es_mem_op[7]: begin
        data_sram_wstrb = 4'b0001 << es_addr[1:0];
        data_sram_wdata = {4{es_st_data[7:0]}};
      end
      es_mem_op[6]: begin
        data_sram_wstrb = es_addr[1] ? 4'b1100
                                     : 4'b0011;
        data_sram_wdata = {2{es_st_data[15:0]}};
      end
      es_mem_op[5]: begin
        data_sram_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Valid bit and payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid    <= 1'b0;
      es_mem_op   <= 8'h00;
      es_base     <= 32'h0;
      es_offset   <= 32'h0;
      es_st_data  <= 32'h0;
      es_pc       <= 32'h0;
      es_dest     <= '0;
      es_gr_we    <= 1'b0;
      es_ds_ex    <= 1'b0;
      es_ds_ecode <= 6'h00;
    end else begin
      if (squash)
        es_valid <= 1'b0;
      else if (es_allowin)
        es_valid <= ds_to_es_valid;
      if (ds_to_es_valid & es_allowin) begin
        es_mem_op   <= ds_mem_op;
        es_base     <= ds_base;
        es_offset   <= ds_offset;
        es_st_data  <= ds_st_data;
        es_pc       <= ds_pc;
        es_dest     <= ds_dest;
        es_gr_we    <= ds_gr_we;
        es_ds_ex    <= ds_ex;
        es_ds_ecode <= ds_ecode;
      end
    end
  end

  // Request FSM; a request once raised is held until addr_ok
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      orphan <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue_ok)
            state <= REQ;
        end
        REQ: begin
          if (data_sram_addr_ok) begin
            orphan <= 1'b0;
            if (orphan | squash | handoff)
              state <= IDLE;
            else
              state <= ACC;
          end else if (squash) begin
            orphan <= 1'b1;
          end
        end
        ACC: begin
          if (squash | handoff)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
